// File: rtl/add_seq_wide.sv
// add_seq_wide: multi-cycle wide adder/subtractor that time-multiplexes one 16-bit slice adder LSB to MSB.
// Operands enter on a valid/ready handshake and the result leaves on another.
module add_seq_wide #(
    parameter int TOTAL_WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOTAL_WIDTH-1:0] a,
    input  logic [TOTAL_WIDTH-1:0] b,
    input  logic                   cin,
    input  logic                   op_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOTAL_WIDTH-1:0] sum,
    output logic                   cout,
    output logic                   ovf
);
    localparam int NSLICE = TOTAL_WIDTH / SLICE;
    localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    localparam int MSB = TOTAL_WIDTH - 1;

    if (SLICE != 16 || TOTAL_WIDTH < SLICE || TOTAL_WIDTH % SLICE != 0) begin : g_bad_width
        $error("add_seq_wide: TOTAL_WIDTH must be a nonzero multiple of SLICE, and SLICE must be 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;

    logic [TOTAL_WIDTH-1:0] a_r, b_r;
    logic                   carry;
    logic [IW-1:0]          idx;
    logic [SLICE-1:0]       a_s, b_s;
    logic [SLICE:0]         s;
    logic                   last, accept;

    assign a_s = a_r[int'(idx)*SLICE +: SLICE];
    assign b_s = b_r[int'(idx)*SLICE +: SLICE];
    assign s = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry};
    assign last = idx == IW'(NSLICE - 1);
    assign accept = state == IDLE && in_valid && in_ready;
    assign out_valid = state == DONE;

    always_comb begin
        state_n = state == IDLE ? (accept ? RUN : IDLE)
                : state == RUN  ? (last ? DONE : RUN)
                : (out_ready ? IDLE : DONE);
    end

    // in_ready is registered so it stays low through every cycle that follows a reset edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state <= state_n;
            in_ready <= state_n == IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
            cout <= 1'b0;
            ovf <= 1'b0;
            idx <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            a_r <= a;
            b_r <= op_sub ? ~b : b;
            carry <= op_sub | cin;
            idx <= '0;
        end else if (state == RUN) begin
            sum[int'(idx)*SLICE +: SLICE] <= s[SLICE-1:0];
            carry <= s[SLICE];
            idx <= idx + 1'b1;
            if (last) begin
                cout <= s[SLICE];
                ovf <= (a_r[MSB] == b_r[MSB]) && (s[SLICE-1] != a_r[MSB]);
            end
        end
    end
endmodule

// File: doc/add_seq_wide.md
# add_seq_wide

Multi-cycle wide adder/subtractor that sits directly upstream of the team's 16-bit CLA adder core. It time-multiplexes that combinational slice adder over a TOTAL_WIDTH-bit operation, one 16-bit slice per cycle from LSB to MSB, chaining each slice's carry-out into the next slice's carry-in. Operands enter and results leave through valid/ready handshakes.

## Interface
- TOTAL_WIDTH, 64, operand/result width; must be an integer multiple of SLICE (elaboration error otherwise)
- SLICE, 16, slice adder width; fixed at 16
- NSLICE, TOTAL_WIDTH/SLICE, derived slice count (localparam)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept an operand
- a  in  TOTAL_WIDTH  operand A
- b  in  TOTAL_WIDTH  operand B
- cin  in  1  carry-in for add; ignored for subtract
- op_sub  in  1  0 = A+B+cin, 1 = A-B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  TOTAL_WIDTH  result, modulo 2^TOTAL_WIDTH
- cout  out  1  carry out of MSB (subtract: 1 = no borrow, A >= B unsigned)
- ovf  out  1  two's-complement signed overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid&in_ready, capture a, the effective B (op_sub ? ~b : b), and carry (op_sub ? 1 : cin); clear slice index; go to RUN.
- RUN: in_ready=0, out_valid=0. Each cycle, present slice idx of A, effective B, and the carry register to the slice adder. Write S into sum[idx*16 +: 16]; write Cout into the carry register; increment idx. At idx=NSLICE-1, write final cout and ovf and go to DONE.
- ovf = (A_msb == Beff_msb) && (sum_msb != A_msb), computed from the last slice.
- DONE: out_valid=1. sum, cout, and ovf are held stable. On out_valid&out_ready, go to IDLE. No operand is accepted in the same cycle.
- Inputs are sampled only at acceptance. Later changes to a, b, cin, and op_sub have no effect on the operation in flight.
- sum is not cleared between operations. Its upper slices keep stale values until overwritten, but they are only meaningful while out_valid=1.

## Timing
- Reset (rst high at an edge): state goes to IDLE; out_valid=0, sum=0, cout=0, ovf=0, idx=0, carry register=0. in_ready is 0 while rst is high and 1 from the first cycle after rst falls.
- Reset mid-RUN or in DONE aborts the operation. No out_valid is produced for the aborted operation, and the partial sum is zeroed.
- Latency: acceptance edge E0; slices written at edges E1..E(NSLICE). out_valid=1 in the cycle after E(NSLICE), i.e. 4 cycles after acceptance for the defaults.
- Minimum initiation interval: NSLICE+2 cycles (acceptance, NSLICE slice cycles, one handoff cycle in DONE/IDLE).
- DONE holds indefinitely under out_ready=0. in_valid is ignored during RUN and DONE.
- Critical path is one 16-bit slice adder plus the carry register. There is no combinational path from inputs to outputs.
- in_ready and out_valid are decoded from state registers only.

## Test plan
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, op_sub=0 -> sum=0, cout=1, ovf=0; out_valid rises exactly 4 cycles after acceptance.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- Subtract, both orderings:
  - a=5, b=7, op_sub=1, cin=1 (cin must be ignored) -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - a=7, b=5 -> sum=2, cout=1.
- Cross-slice carry-in: a=0x0000_0000_0000_FFFF, b=0, cin=1 -> sum=0x0000_0000_0001_0000, cout=0.
- Backpressure and input isolation:
  - Hold out_ready=0 for 10 cycles in DONE and toggle a/b/in_valid -> sum/cout/ovf unchanged, in_ready=0.
  - Raise out_ready -> IDLE next cycle. A back-to-back second operation completes with the correct result.
- Reset mid-operation: assert rst for 1 cycle after 2 slices of a=b=0xFFFF_FFFF_FFFF_FFFF.
  - Required: out_valid never asserts for that operation, sum=0, and in_ready=1 the cycle after rst falls.
  - A subsequent op 1+2 gives sum=3.
